cpu_ctrl: RTL and testbench

- Sequencer on the controlling side of the 4-bit ALU. It fetches 8-bit instructions from an external instruction ROM and decodes them.
- Holds a 4x4-bit register file. Drives ALU operands and the op select, then consumes the ALU's RES/eq/ovf to write back results, branch and set flags.
- Sits between instruction memory and the existing combinational ALU. It is the first clocked block of the CPU core.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/regfile_4x4.sv | 40 ++++
 rtl/cpu_ctrl.sv | 136 +++++++++++++
 tb/tb_cpu_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcodes, CTL sub-codes, FSM states and field positions
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_NAND  = 2'b01;
    localparam logic [1:0] OP_LDI   = 2'b10;
    localparam logic [1:0] OP_CTL   = 2'b11;

    localparam logic [1:0] SUB_SEQ  = 2'b00;
    localparam logic [1:0] SUB_JMP  = 2'b01;
    localparam logic [1:0] SUB_HALT = 2'b10;
    localparam logic [1:0] SUB_NOP  = 2'b11;

    localparam int OP_LSB = 6;
    localparam int F1_LSB = 4;
    localparam int F2_LSB = 2;
    localparam int F3_LSB = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    function automatic logic [1:0] fld(input logic [7:0] instr, input int lsb);
        return instr[lsb +: 2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_4x4.sv
// ============================================================================
// Module      : regfile_4x4
// Description : 4x4-bit register file, two operand reads, one debug read
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_4x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [3:0] wdata_i,
    input  logic [1:0] raddr_a_i,
    input  logic [1:0] raddr_b_i,
    input  logic [1:0] dbg_sel_i,
    output logic [3:0] rdata_a_o,
    output logic [3:0] rdata_b_o,
    output logic [3:0] dbg_data_o
);

    logic [3:0] mem_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = mem_q[raddr_a_i];
    assign rdata_b_o  = mem_q[raddr_b_i];
    assign dbg_data_o = mem_q[dbg_sel_i];

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// ============================================================================
// Module      : cpu_ctrl
// Description : Fetch/exec/writeback sequencer driving the external 4-bit ALU
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_data,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic            alu_sel,
    input  logic [3:0]      alu_res,
    input  logic            alu_eq,
    input  logic            alu_ovf,
    output logic            ovf_flag,
    output logic            halted,
    input  logic [1:0]      dbg_sel,
    output logic [3:0]      dbg_data
);

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [7:0]      instr_q;
    logic [3:0]      res_q;
    logic            eq_q;
    logic            ovf_q;
    logic            ovf_flag_q;
    logic            halted_q;

    logic [1:0]      w_op;
    logic [1:0]      w_sub;
    logic [1:0]      w_rd;
    logic [1:0]      w_ra;
    logic [1:0]      w_rb;
    logic            w_is_ctl;
    logic            w_we;

    assign w_op     = fld(instr_q, OP_LSB);
    assign w_rd     = fld(instr_q, F1_LSB);
    assign w_sub    = fld(instr_q, F3_LSB);
    assign w_is_ctl = (w_op == OP_CTL);

    // CTL compares/jumps on f1/f2; arithmetic reads its sources from f2/f3.
    assign w_ra = w_is_ctl ? fld(instr_q, F1_LSB) : fld(instr_q, F2_LSB);
    assign w_rb = w_is_ctl ? fld(instr_q, F2_LSB) : fld(instr_q, F3_LSB);

    assign w_we = en && (state_q == ST_WB) && !w_is_ctl;

    regfile_4x4 u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (w_we),
        .waddr_i    (w_rd),
        .wdata_i    (res_q),
        .raddr_a_i  (w_ra),
        .raddr_b_i  (w_rb),
        .dbg_sel_i  (dbg_sel),
        .rdata_a_o  (alu_a),
        .rdata_b_o  (alu_b),
        .dbg_data_o (dbg_data)
    );

    assign alu_sel   = (w_op == OP_NAND);
    assign imem_addr = pc_q;
    assign ovf_flag  = ovf_flag_q;
    assign halted    = halted_q;

    // JMP target is R[rs], which is exactly what operand A carries for CTL.
    always_comb begin
        pc_d = pc_q + PC_W'(1);
        if (w_is_ctl) begin
            if (w_sub == SUB_SEQ && eq_q) begin
                pc_d = pc_q + PC_W'(2);
            end else if (w_sub == SUB_JMP) begin
                pc_d = PC_W'(alu_a);
            end else if (w_sub == SUB_HALT) begin
                pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 8'h00;
            res_q      <= '0;
            eq_q       <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_flag_q <= 1'b0;
            halted_q   <= 1'b0;
        end else if (en) begin
            case (state_q)
                ST_FETCH: begin
                    instr_q <= imem_data;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q   <= (w_op == OP_LDI) ? instr_q[3:0] : alu_res;
                    eq_q    <= alu_eq;
                    ovf_q   <= alu_ovf;
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    pc_q <= pc_d;
                    if (w_op == OP_ADD) begin
                        ovf_flag_q <= ovf_q;
                    end
                    if (w_is_ctl && w_sub == SUB_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        state_q  <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// ============================================================================
// Module      : tb_cpu_ctrl
// Description : Scoreboard bench for cpu_ctrl with a behavioural ROM and ALU
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_ctrl;

    localparam int PC_W = 4;

    localparam int K_REG  = 0;
    localparam int K_PC   = 1;
    localparam int K_OVF  = 2;
    localparam int K_HALT = 3;
    localparam int K_ALUA = 4;
    localparam int K_ALUB = 5;

    localparam logic [7:0] I_HALT = 8'hC2;
    localparam logic [7:0] I_NOP  = 8'hC3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_data;
    logic [3:0]      alu_a;
    logic [3:0]      alu_b;
    logic            alu_sel;
    logic [3:0]      alu_res;
    logic            alu_eq;
    logic            alu_ovf;
    logic            ovf_flag;
    logic            halted;
    logic [1:0]      dbg_sel = 2'd0;
    logic [3:0]      dbg_data;

    logic [7:0]      rom [16];
    logic [3:0]      w_sum;

    typedef struct {
        int         kind;
        int         idx;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #50 clk = ~clk;

    // Behavioural ALU and ROM around the controller.
    assign imem_data = rom[imem_addr];
    assign w_sum     = alu_a + alu_b;
    assign alu_res   = alu_sel ? ~(alu_a & alu_b) : w_sum;
    assign alu_eq    = (alu_a == alu_b);
    assign alu_ovf   = (alu_a[3] == alu_b[3]) && (w_sum[3] != alu_a[3]);

    cpu_ctrl #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_res   (alu_res),
        .alu_eq    (alu_eq),
        .alu_ovf   (alu_ovf),
        .ovf_flag  (ovf_flag),
        .halted    (halted),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    function automatic logic [7:0] i_ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {2'b10, rd, imm};
    endfunction
    function automatic logic [7:0] i_add(input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
        return {2'b00, rd, rs, rt};
    endfunction
    function automatic logic [7:0] i_nand(input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
        return {2'b01, rd, rs, rt};
    endfunction
    function automatic logic [7:0] i_seq(input logic [1:0] rs, input logic [1:0] rt);
        return {2'b11, rs, rt, 2'b00};
    endfunction
    function automatic logic [7:0] i_jmp(input logic [1:0] rs);
        return {2'b11, rs, 2'b00, 2'b01};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = I_HALT;
    endtask

    task automatic push(input int k, input int idx, input logic [7:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.idx  = idx;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic observe(input int k, input int idx, output logic [7:0] v);
        case (k)
            K_REG: begin
                dbg_sel = 2'(idx);
                #1;
                v = {4'b0, dbg_data};
            end
            K_PC:   v = {4'b0, imem_addr};
            K_OVF:  v = {7'b0, ovf_flag};
            K_HALT: v = {7'b0, halted};
            K_ALUA: v = {4'b0, alu_a};
            default: v = {4'b0, alu_b};
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [7:0] got;
        clear_rom();
        rom[0] = i_ldi(2'd1, 4'h7);
        rom[1] = i_ldi(2'd2, 4'h9);
        rom[2] = i_add(2'd3, 2'd1, 2'd2);
        do_reset();
        repeat (7) @(negedge clk);
        push(K_ALUA, 0, 8'h07, "pre_alu_a");
        push(K_ALUB, 0, 8'h09, "pre_alu_b");
        push(K_REG,  1, 8'h07, "pre_r1");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            observe(e.kind, e.idx, got);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        rst_n = 1'b0;
        #2;
        push(K_PC,   0, 8'h00, "rst_pc");
        push(K_HALT, 0, 8'h00, "rst_halted");
        push(K_OVF,  0, 8'h00, "rst_ovf");
        push(K_ALUA, 0, 8'h00, "rst_alu_a");
        push(K_ALUB, 0, 8'h00, "rst_alu_b");
        for (int r = 0; r < 4; r++) push(K_REG, r, 8'h00, $sformatf("rst_r%0d", r));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            observe(e.kind, e.idx, got);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        push(K_HALT, 0, 8'h01, "rerun_halted");
        push(K_REG,  3, 8'h00, "rerun_r3");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            observe(e.kind, e.idx, got);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_add();
        exp_t e;
        logic [7:0] got;
        logic [3:0] b_vals [2];
        b_vals[0] = 4'h9;
        b_vals[1] = 4'h1;
        for (int p = 0; p < 2; p++) begin
            clear_rom();
            rom[0] = i_ldi(2'd1, 4'h7);
            rom[1] = i_ldi(2'd2, b_vals[p]);
            rom[2] = i_add(2'd3, 2'd1, 2'd2);
            rom[3] = I_HALT;
            do_reset();
            repeat (11) @(negedge clk);
            push(K_HALT, 0, 8'h00, "add_halted_early");
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e.kind, e.idx, got);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                end
            end
            @(negedge clk);
            push(K_HALT, 0, 8'h01, "add_halted");
            push(K_PC,   0, 8'h03, "add_pc");
            push(K_REG,  1, 8'h07, "add_r1");
            push(K_REG,  3, (p == 0) ? 8'h00 : 8'h08, "add_r3");
            push(K_OVF,  0, (p == 0) ? 8'h00 : 8'h01, "add_ovf");
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e.kind, e.idx, got);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                end
            end
        end
    endtask

    task automatic test_seq();
        exp_t e;
        logic [7:0] got;
        for (int p = 0; p < 2; p++) begin
            clear_rom();
            rom[0] = i_ldi(2'd1, 4'h5);
            rom[1] = i_ldi(2'd2, (p == 0) ? 4'h5 : 4'h6);
            rom[2] = i_seq(2'd1, 2'd2);
            rom[3] = i_ldi(2'd0, 4'hF);
            rom[4] = I_HALT;
            do_reset();
            repeat (15) @(negedge clk);
            push(K_REG,  0, (p == 0) ? 8'h00 : 8'h0F, "seq_r0");
            push(K_PC,   0, 8'h04, "seq_pc");
            push(K_HALT, 0, 8'h01, "seq_halted");
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e.kind, e.idx, got);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                end
            end
        end
    endtask

    task automatic test_nand();
        exp_t e;
        logic [7:0] got;
        clear_rom();
        rom[0] = i_ldi(2'd1, 4'h7);
        rom[1] = i_ldi(2'd2, 4'h1);
        rom[2] = i_add(2'd3, 2'd1, 2'd2);
        rom[3] = i_ldi(2'd1, 4'hC);
        rom[4] = i_nand(2'd2, 2'd1, 2'd1);
        rom[5] = I_HALT;
        do_reset();
        repeat (18) @(negedge clk);
        push(K_REG,  2, 8'h03, "nand_r2");
        push(K_REG,  3, 8'h08, "nand_r3");
        push(K_OVF,  0, 8'h01, "nand_ovf_kept");
        push(K_PC,   0, 8'h05, "nand_pc");
        push(K_HALT, 0, 8'h01, "nand_halted");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            observe(e.kind, e.idx, got);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_jmp_wrap_en();
        exp_t e;
        logic [7:0] got;
        for (int p = 0; p < 2; p++) begin
            clear_rom();
            rom[0]  = i_ldi(2'd1, 4'hF);
            rom[1]  = i_ldi(2'd2, 4'hA);
            rom[2]  = i_jmp(2'd1);
            rom[15] = I_NOP;
            do_reset();
            @(negedge clk);
            rom[0] = I_HALT;
            repeat (3) @(negedge clk);
            if (p == 1) begin
                en = 1'b0;
                repeat (5) @(negedge clk);
                push(K_PC,   0, 8'h01, "frz_pc");
                push(K_REG,  1, 8'h0F, "frz_r1");
                push(K_REG,  2, 8'h00, "frz_r2");
                push(K_HALT, 0, 8'h00, "frz_halted");
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    observe(e.kind, e.idx, got);
                    checks++;
                    if (got !== e.val) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                    end
                end
                en = 1'b1;
            end
            repeat (10) @(negedge clk);
            push(K_HALT, 0, 8'h00, "jmp_halted_early");
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e.kind, e.idx, got);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                end
            end
            @(negedge clk);
            push(K_HALT, 0, 8'h01, "jmp_halted");
            push(K_PC,   0, 8'h00, "jmp_pc_wrap");
            push(K_REG,  1, 8'h0F, "jmp_r1");
            push(K_REG,  2, 8'h0A, "jmp_r2");
            while (sb.size() > 0) begin
                e = sb.pop_front();
                observe(e.kind, e.idx, got);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.val);
                end
            end
        end
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_add();
        test_seq();
        test_nand();
        test_jmp_wrap_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
